// File: rtl/ysyx_24080006_pkg.sv
// Shared I-cache geometry and line storage type.
// Used by the cache controller and the line storage array.
package ysyx_24080006_pkg;

  localparam int IC_N = 4;
  localparam int IC_M = 4;
  localparam int IC_T = 32 - IC_N - IC_M;
  localparam int IC_2 = 1 << IC_N;

  typedef struct packed {
    logic             valid;
    logic [IC_T-1:0]  tag;
    logic [3:0][31:0] data;
  } icache_t;

  function automatic logic [31:0] line_base(
    input logic [31:0] a
  );
    return {a[31:IC_M], {IC_M{1'b0}}};
  endfunction

endpackage

// File: rtl/ysyx_24080006_icache_ctrl.sv
// Direct-mapped I-cache controller with AXI4 INCR line refill.
// Optional hit/miss counters: YSYX_24080006_ICACHE_PERF_EN.
module ysyx_24080006_icache_ctrl
  import ysyx_24080006_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            ifu_valid,
  output logic            ifu_ready,
  input  logic [31:0]     ifu_addr,
  input  logic            fence_i,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_inst,
  output logic            rsp_err,
  output logic [IC_N-1:0] ic_index,
  input  icache_t         ic_rdata,
  output logic            ic_we,
  output icache_t         ic_wdata,
  output logic            arvalid,
  input  logic            arready,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  input  logic            rvalid,
  output logic            rready,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast
`ifdef YSYX_24080006_ICACHE_PERF_EN
  ,
  output logic [31:0]     perf_hit,
  output logic [31:0]     perf_miss
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    AR,
    R,
    FILL,
    RESP,
    FLUSH
  } state_t;

  localparam logic [IC_N-1:0] LAST_IDX = IC_N'(IC_2 - 1);

  state_t           state;
  logic [31:0]      addr;
  logic [3:0][31:0] line_buf;
  logic [1:0]       beat;
  logic             err;
  logic             fence_pend;
  logic [IC_N-1:0]  fcnt;

  logic [IC_T-1:0]  tag;
  logic [1:0]       word;
  logic             hit;
  logic             rresp_bad;
  logic             err_now;
  logic             unused_bits;

  assign tag       = addr[31:IC_M+IC_N];
  assign word      = addr[3:2];
  assign hit       = ic_rdata.valid && (ic_rdata.tag == tag);
  assign rresp_bad = (rresp != 2'b00);
  assign err_now   = err | rresp_bad;

  assign araddr      = line_base(addr);
  assign arlen       = 8'd3;
  assign arsize      = 3'd2;
  assign arburst     = 2'b01;
  assign unused_bits = ^addr[1:0];

  always_comb begin
    ic_index = addr[IC_M+IC_N-1:IC_M];
    ic_wdata = '0;
    if (state == FLUSH) begin
      ic_index = fcnt;
    end
    if (state == FILL) begin
      ic_wdata.valid = 1'b1;
      ic_wdata.tag   = tag;
      ic_wdata.data  = line_buf;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr       <= '0;
      line_buf   <= '0;
      beat       <= '0;
      err        <= 1'b0;
      fence_pend <= 1'b0;
      fcnt       <= '0;
      ifu_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_inst   <= '0;
      rsp_err    <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      ic_we      <= 1'b0;
`ifdef YSYX_24080006_ICACHE_PERF_EN
      perf_hit   <= '0;
      perf_miss  <= '0;
`endif
    end else begin
      // Fence arriving mid-transaction waits for the next IDLE.
      if (fence_i && state != IDLE && state != FLUSH) begin
        fence_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (fence_i || fence_pend) begin
            state      <= FLUSH;
            fence_pend <= 1'b0;
            ifu_ready  <= 1'b0;
            ic_we      <= 1'b1;
            fcnt       <= '0;
          end else if (ifu_valid && ifu_ready) begin
            state     <= CHECK;
            addr      <= ifu_addr;
            ifu_ready <= 1'b0;
            err       <= 1'b0;
            line_buf  <= '0;
            beat      <= '0;
          end else begin
            ifu_ready <= 1'b1;
          end
        end
        CHECK: begin
          if (hit) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_inst  <= ic_rdata.data[word];
            rsp_err   <= 1'b0;
`ifdef YSYX_24080006_ICACHE_PERF_EN
            if (perf_hit != '1) perf_hit <= perf_hit + 32'd1;
`endif
          end else begin
            state   <= AR;
            arvalid <= 1'b1;
`ifdef YSYX_24080006_ICACHE_PERF_EN
            if (perf_miss != '1) perf_miss <= perf_miss + 32'd1;
`endif
          end
        end
        AR: begin
          if (arready) begin
            state   <= R;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        R: begin
          if (rvalid) begin
            line_buf[beat] <= rdata;
            beat           <= beat + 2'd1;
            if (rresp_bad) err <= 1'b1;
            if (rlast) begin
              state  <= FILL;
              rready <= 1'b0;
              ic_we  <= ~err_now;
            end
          end
        end
        FILL: begin
          state     <= RESP;
          ic_we     <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rsp_inst  <= err ? 32'd0 : line_buf[word];
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            ifu_ready <= ~(fence_pend | fence_i);
          end
        end
        FLUSH: begin
          fcnt <= fcnt + 1'b1;
          if (fcnt == LAST_IDX) begin
            state     <= IDLE;
            ic_we     <= 1'b0;
            ifu_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ysyx_24080006_icache_ctrl.md
YSYX_24080006_ICACHE_CTRL -- requirements
Module: ysyx_24080006_icache_ctrl

Interface
REQ-001 SHALL use package constants: IC_N, 4, index bits; IC_M, 4, line-offset bits (16-byte line, 4 words); IC_T, 32-IC_N-IC_M, tag bits.
REQ-002 SHALL have ports: clock  in  1  system clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have fetch ports: ifu_valid in 1; ifu_ready out 1; ifu_addr in 32, word-aligned PC; fence_i in 1, invalidate request.
REQ-004 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_inst out 32; rsp_err out 1, bus error.
REQ-005 SHALL have storage ports: ic_index out IC_N; ic_rdata in icache_t, combinational read of the indexed line; ic_we out 1; ic_wdata out icache_t.
REQ-006 SHALL have AXI4 read ports: arvalid out 1; arready in 1; araddr out 32; arlen out 8; arsize out 3; arburst out 2; rvalid in 1; rready out 1; rdata in 32; rresp in 2; rlast in 1.

Function
REQ-007 SHALL implement states IDLE, CHECK, AR, R, FILL, RESP, FLUSH.
REQ-008 In IDLE: ifu_ready=1; fence_i has priority over ifu_valid and enters FLUSH; ifu_valid&ifu_ready latches ifu_addr and enters CHECK.
REQ-009 ic_index SHALL equal latched addr[IC_M+IC_N-1:IC_M] outside FLUSH; in FLUSH it SHALL equal the flush counter.
REQ-010 CHECK: hit = ic_rdata.valid & tag match; hit -> RESP with the selected word (addr[3:2]); miss -> AR.
REQ-011 Hit latency SHALL be 1 cycle: request accepted cycle N, rsp_valid at N+1.
REQ-012 AR: arvalid=1, araddr=line base (low IC_M bits zero), arlen=3, arsize=2, arburst=INCR(01); hold stable until arready, then R.
REQ-013 R: rready=1; beats stored in order into a 4-word buffer; any rresp!=0 sets a sticky error; on rvalid&rlast -> FILL.
REQ-014 FILL: one-cycle ic_we=1 with {valid=1, tag, buffered data} when no error; on error no write, sticky error cleared at next request; then RESP.
REQ-015 RESP: rsp_valid=1, rsp_inst/rsp_err held stable until rsp_ready; then IDLE; rsp_valid SHALL never drop without rsp_ready.
REQ-016 Bus error response: rsp_err=1, rsp_inst=0; the line SHALL stay invalid.
REQ-017 FLUSH: counter walks 0..IC_2-1, ic_we=1 with ic_wdata='0 each cycle (IC_2 cycles); ifu_ready=0; return to IDLE after last index; fence_i during FLUSH ignored.
REQ-018 fence_i while not in IDLE SHALL be recorded and serviced at the next IDLE, before any fetch.
REQ-019 rlast arriving before 4 beats SHALL still end R; unreceived words are 0.

Reset
REQ-020 While reset=0: state=IDLE, ifu_ready=0, rsp_valid=0, rsp_err=0, rsp_inst=0, arvalid=0, rready=0, ic_we=0, counters and buffer zero; ifu_ready=1 from the first edge after release.
REQ-021 Reset mid-burst SHALL abandon the transaction with no storage write.

Configuration
REQ-022 Macro YSYX_24080006_ICACHE_PERF_EN: when defined, outputs perf_hit and perf_miss (32 bits each, reset 0, saturating) count CHECK hits/misses; when undefined those ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-023 icache_t {valid, tag[IC_T], data[4][32]}, IC_N, IC_M, IC_T, IC_2 SHALL live in ysyx_24080006_pkg; the state enum is local.
REQ-024 SHALL instantiate no sub-module; it connects to ysyx_24080006_icache_reg at the parent level.

Verification
REQ-025 Cold miss ifu_addr=0x8000_0004, memory beats 11,22,33,44 -> araddr=0x8000_0000, arlen=3, one ic_we, rsp_inst=0x22, rsp_err=0.
REQ-026 Repeat fetch 0x8000_000C -> no arvalid, rsp_valid one cycle after accept, rsp_inst=0x44.
REQ-027 Conflict: fetch 0x8000_0100 (same index, new tag) -> refill, then 0x8000_0000 misses again.
REQ-028 rresp=2 on beat 1 -> rsp_err=1, rsp_inst=0, no ic_we, next fetch of same line misses.
REQ-029 fence_i after fills -> exactly IC_2 zero writes, ifu_ready=0 throughout, next fetch misses.
REQ-030 rsp_ready held 0 for 5 cycles, and reset=0 asserted mid-R -> response stable while stalled; after reset all outputs at reset values, no write.
